rx_os_consensus: RTL and testbench

Parametrised receive-side ordered-set consensus engine for the LTSSM receive path. It runs one training-set checker and one saturating counter per lane across `NUM_LANES` lanes. It qualifies each received TS against the expected type and link number, and enforces per-lane rate-ID consistency. A single FSM reports success once the required lanes reach the consecutive-match threshold ("all detected" or "any detected" mode), or reports timeout via a built-in cycle timer. It is the generalised successor to the fixed 16-lane checker/counter/comparator arrangement and sits between the ordered-set deframer and the LTSSM substate controller.

---
 rtl/rx_os_consensus_if.sv | 38 +++
 rtl/rx_os_consensus.sv | 145 ++++++++++++++
 tb/tb_rx_os_consensus.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_os_consensus_if.sv
// Bus between the ordered-set deframer/LTSSM controller and the RX ordered-set
// consensus engine.
interface rx_os_consensus_if #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned OS_W      = 128,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned TMR_W     = 24
);
  logic                      start;
  logic                      abort;
  logic [NUM_LANES*OS_W-1:0] orderedSets;
  logic                      validOrderedSets;
  logic [5:0]                numberOfDetectedLanes;
  logic [7:0]                expectedType;
  logic [7:0]                linkNumber;
  logic                      checkLink;
  logic                      checkLane;
  logic [CNT_W-1:0]          threshold;
  logic [TMR_W-1:0]          timeoutCycles;
  logic                      busy;
  logic                      finish;
  logic                      success;
  logic [NUM_LANES-1:0]      laneQualified;
  logic [7:0]                rateId;
  logic [7:0]                linkNumberOut;

  modport master (
    output start, abort, orderedSets, validOrderedSets, numberOfDetectedLanes,
           expectedType, linkNumber, checkLink, checkLane, threshold, timeoutCycles,
    input  busy, finish, success, laneQualified, rateId, linkNumberOut
  );

  modport slave (
    input  start, abort, orderedSets, validOrderedSets, numberOfDetectedLanes,
           expectedType, linkNumber, checkLink, checkLane, threshold, timeoutCycles,
    output busy, finish, success, laneQualified, rateId, linkNumberOut
  );
endinterface

// File: rtl/rx_os_consensus.sv
// Per-lane TS qualification with consecutive-match counters and a single
// IDLE/COUNT/DONE FSM that reports success or timeout.
module rx_os_consensus #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned OS_W      = 128,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned TMR_W     = 24,
  parameter int unsigned ANY_MODE  = 0
) (
  input logic              clk,
  input logic              reset,
  rx_os_consensus_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t               state, stateNext;
  logic [CNT_W-1:0]     cnt [NUM_LANES];
  logic [7:0]           rid [NUM_LANES];
  logic [7:0]           lnk [NUM_LANES];
  logic [31:0]          laneField [NUM_LANES];
  logic [NUM_LANES-1:0] active, match, qualNow, laneQ;
  logic [CNT_W-1:0]     thrReg, thrEff;
  logic [TMR_W-1:0]     tmoReg, timer;
  logic [7:0]           rateReg, linkReg, capRate, capLink;
  logic [5:0]           nClamp;
  logic                 succReg, succNow, timeoutNow, capture, found;

  always_comb begin
    nClamp  = (bus.numberOfDetectedLanes > 6'(NUM_LANES)) ? 6'(NUM_LANES)
                                                          : bus.numberOfDetectedLanes;
    thrEff  = (thrReg == '0) ? CNT_W'(1) : thrReg;
    capRate = '0;
    capLink = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      laneField[i] = bus.orderedSets[i*OS_W +: 32];
      active[i]    = (6'(i) < nClamp);
      match[i]     = (laneField[i][7:0] == bus.expectedType)
                  && (!bus.checkLink || laneField[i][15:8] == bus.linkNumber)
                  && (!bus.checkLane || laneField[i][23:16] == 8'(i));
      qualNow[i]   = active[i] && (cnt[i] >= thrEff);
      if (qualNow[i] && !found) begin
        found   = 1'b1;
        capRate = rid[i];
        capLink = lnk[i];
      end
    end
    if (ANY_MODE != 0)
      succNow = |qualNow;
    else
      succNow = (nClamp != '0) && (&(qualNow | ~active));
    timeoutNow = (tmoReg != '0) && (timer == tmoReg - 1'b1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    if (bus.start) begin
      stateNext = COUNT;
    end else if (bus.abort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:  stateNext = IDLE;
        COUNT: begin
          // success takes priority over a timeout in the same cycle
          if (succNow || timeoutNow) stateNext = DONE;
          capture = succNow;
        end
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
    bus.busy          = (state == COUNT);
    bus.finish        = (state == DONE);
    bus.success       = succReg;
    bus.laneQualified = laneQ;
    bus.rateId        = rateReg;
    bus.linkNumberOut = linkReg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thrReg  <= '0;
      tmoReg  <= '0;
      timer   <= '0;
      laneQ   <= '0;
      succReg <= 1'b0;
      rateReg <= '0;
      linkReg <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        cnt[i] <= '0;
        rid[i] <= '0;
        lnk[i] <= '0;
      end
    end else begin
      laneQ   <= (bus.start || bus.abort) ? '0 : qualNow;
      succReg <= capture;
      if (capture) begin
        rateReg <= capRate;
        linkReg <= capLink;
      end
      if (bus.start) begin
        thrReg <= bus.threshold;
        tmoReg <= bus.timeoutCycles;
        timer  <= '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          cnt[i] <= '0;
          rid[i] <= '0;
          lnk[i] <= '0;
        end
      end else if (bus.abort) begin
        timer <= '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
      end else if (state == COUNT) begin
        timer <= timer + 1'b1;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (!active[i]) begin
            cnt[i] <= '0;
          end else if (bus.validOrderedSets) begin
            if (match[i]) begin
              // a rate-ID change restarts the run at 1 rather than 0
              if (cnt[i] == '0 || rid[i] != laneField[i][31:24]) begin
                rid[i] <= laneField[i][31:24];
                cnt[i] <= CNT_W'(1);
              end else if (cnt[i] != '1) begin
                cnt[i] <= cnt[i] + 1'b1;
              end
              lnk[i] <= laneField[i][15:8];
            end else begin
              cnt[i] <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_os_consensus.sv
// Scoreboard bench for rx_os_consensus: two instances (all-lanes and any-lane
// mode) share stimulus; expectations come from a cycle-level reference model.
module tb_rx_os_consensus;
  localparam int unsigned NL   = 4;
  localparam int unsigned MAXJ = 128;

  typedef struct {
    logic          succ;
    logic [7:0]    rate;
    logic [7:0]    link;
    logic [NL-1:0] qual;
    int unsigned   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  int unsigned cfgN, cfgThr, cfgTmo;
  bit          cfgChkLink, cfgChkLane;
  logic [7:0]  cfgType, cfgLink;
  logic        stV [MAXJ+2];
  logic [31:0] stF [MAXJ+2][NL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_os_consensus_if #(.NUM_LANES(NL), .OS_W(128), .CNT_W(5), .TMR_W(24)) bus0();
  rx_os_consensus_if #(.NUM_LANES(NL), .OS_W(128), .CNT_W(5), .TMR_W(24)) bus1();

  assign bus1.start                 = bus0.start;
  assign bus1.abort                 = bus0.abort;
  assign bus1.orderedSets           = bus0.orderedSets;
  assign bus1.validOrderedSets      = bus0.validOrderedSets;
  assign bus1.numberOfDetectedLanes = bus0.numberOfDetectedLanes;
  assign bus1.expectedType          = bus0.expectedType;
  assign bus1.linkNumber            = bus0.linkNumber;
  assign bus1.checkLink             = bus0.checkLink;
  assign bus1.checkLane             = bus0.checkLane;
  assign bus1.threshold             = bus0.threshold;
  assign bus1.timeoutCycles         = bus0.timeoutCycles;

  rx_os_consensus #(.NUM_LANES(NL), .OS_W(128), .CNT_W(5), .TMR_W(24), .ANY_MODE(0))
    dutAll (.clk(clk), .reset(reset), .bus(bus0));
  rx_os_consensus #(.NUM_LANES(NL), .OS_W(128), .CNT_W(5), .TMR_W(24), .ANY_MODE(1))
    dutAny (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareExp(input string who, input exp_t e, input logic s,
                            input logic [7:0] r, input logic [7:0] l, input logic [NL-1:0] q);
    chk({who, "_finish_cycle"}, cyc, e.cyc);
    chk({who, "_success"}, 32'(s), 32'(e.succ));
    chk({who, "_laneQualified"}, 32'(q), 32'(e.qual));
    if (e.succ) begin
      chk({who, "_rateId"}, 32'(r), 32'(e.rate));
      chk({who, "_linkNumberOut"}, 32'(l), 32'(e.link));
    end
  endtask

  // Monitor: every finish pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (bus0.finish) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL all_unexpected_finish actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = q0.pop_front();
          compareExp("all", e, bus0.success, bus0.rateId, bus0.linkNumberOut, bus0.laneQualified);
        end
      end
      if (bus1.finish) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL any_unexpected_finish actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = q1.pop_front();
          compareExp("any", e, bus1.success, bus1.rateId, bus1.linkNumberOut, bus1.laneQualified);
        end
      end
    end
  end

  // Reference model: cycle j (1-based after the start edge) sees counts built
  // from sets 1..j-1; the run ends in cycle j, finish shows in cycle j+1.
  task automatic model(input bit anyMode, input int unsigned s, output exp_t e,
                       output int unsigned endJ);
    int unsigned   cnt [NL];
    logic [7:0]    rid [NL];
    logic [7:0]    lnk [NL];
    int unsigned   thrE, n;
    logic [NL-1:0] qual;
    bit            succ, found;
    logic [31:0]   f;
    thrE = (cfgThr == 0) ? 1 : cfgThr;
    n    = (cfgN > NL) ? NL : cfgN;
    endJ = 0;
    e    = '{succ: 1'b0, rate: 8'h00, link: 8'h00, qual: '0, cyc: 0};
    for (int unsigned i = 0; i < NL; i++) begin
      cnt[i] = 0; rid[i] = 8'h00; lnk[i] = 8'h00;
    end
    for (int unsigned j = 1; j <= MAXJ; j++) begin
      qual = '0;
      for (int unsigned i = 0; i < n; i++) if (cnt[i] >= thrE) qual[i] = 1'b1;
      succ = anyMode ? (qual != '0) : (n >= 1 && qual == NL'((1 << n) - 1));
      if (succ || (cfgTmo != 0 && j == cfgTmo)) begin
        e.succ = succ;
        e.qual = qual;
        e.cyc  = s + j;
        found  = 1'b0;
        for (int unsigned i = 0; i < n; i++)
          if (qual[i] && !found) begin
            found = 1'b1; e.rate = rid[i]; e.link = lnk[i];
          end
        endJ = j;
        return;
      end
      if (stV[j]) begin
        for (int unsigned i = 0; i < n; i++) begin
          f = stF[j][i];
          if (f[7:0] == cfgType && (!cfgChkLink || f[15:8] == cfgLink)
              && (!cfgChkLane || f[23:16] == 8'(i))) begin
            if (cnt[i] == 0 || rid[i] != f[31:24]) begin
              rid[i] = f[31:24]; cnt[i] = 1;
            end else if (cnt[i] < 31) begin
              cnt[i]++;
            end
            lnk[i] = f[15:8];
          end else begin
            cnt[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic driveSet(input int unsigned j);
    logic [NL*128-1:0] os;
    os = '0;
    for (int unsigned i = 0; i < NL; i++)
      os[i*128 +: 128] = {64'h0, 32'($urandom), stF[j][i]};
    bus0.validOrderedSets = stV[j];
    bus0.orderedSets      = os;
  endtask

  // cut = 0: full run with queued expectations; cut > 0: drive cut sets only.
  task automatic runTest(input int unsigned cut);
    exp_t e0, e1;
    int unsigned j0, j1, s, last;
    @(negedge clk);
    bus0.numberOfDetectedLanes = 6'(cfgN);
    bus0.expectedType          = cfgType;
    bus0.linkNumber            = cfgLink;
    bus0.checkLink             = cfgChkLink;
    bus0.checkLane             = cfgChkLane;
    bus0.threshold             = 5'(cfgThr);
    bus0.timeoutCycles         = 24'(cfgTmo);
    bus0.validOrderedSets      = 1'b0;
    bus0.abort                 = 1'b0;
    bus0.start                 = 1'b1;
    s = cyc + 1;
    if (cut == 0) begin
      model(1'b0, s, e0, j0);
      model(1'b1, s, e1, j1);
      if (j0 != 0) q0.push_back(e0);
      if (j1 != 0) q1.push_back(e1);
      last = ((j0 > j1) ? j0 : j1) + 1;
      if (j0 == 0 || j1 == 0) last = MAXJ;
    end else begin
      last = cut;
    end
    for (int unsigned j = 1; j <= last; j++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      driveSet(j);
    end
    if (cut == 0) begin
      @(negedge clk);
      bus0.validOrderedSets = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (q0.size() == 0 && q1.size() == 0) break;
        @(negedge clk);
      end
      chk("pending_expectations", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic fillMatching(input logic [7:0] rate0);
    for (int unsigned j = 0; j < MAXJ + 2; j++) begin
      stV[j] = 1'b1;
      for (int unsigned i = 0; i < NL; i++)
        stF[j][i] = {(i == 0) ? rate0 : 8'(8'h10 + i), cfgLink, 8'(i), cfgType};
    end
  endtask

  task automatic setCfg(input int unsigned n, input int unsigned thr, input int unsigned tmo);
    cfgN = n; cfgThr = thr; cfgTmo = tmo;
    cfgChkLink = 1'b1; cfgChkLane = 1'b1; cfgType = 8'h1E; cfgLink = 8'h05;
  endtask

  task automatic genRandom();
    logic [7:0]  rate [NL];
    logic [7:0]  lk [NL];
    logic [31:0] f;
    int unsigned r;
    cfgN       = $urandom_range(0, 6);
    cfgThr     = $urandom_range(0, 8);
    cfgTmo     = $urandom_range(15, 70);
    cfgChkLink = 1'($urandom_range(0, 1));
    cfgChkLane = 1'($urandom_range(0, 1));
    cfgType    = ($urandom_range(0, 1) != 0) ? 8'h1E : 8'h2D;
    cfgLink    = 8'($urandom);
    for (int unsigned i = 0; i < NL; i++) begin
      rate[i] = 8'($urandom);
      lk[i]   = cfgChkLink ? cfgLink : 8'($urandom);
    end
    for (int unsigned j = 0; j < MAXJ + 2; j++) begin
      stV[j] = ($urandom_range(0, 7) != 0);
      for (int unsigned i = 0; i < NL; i++) begin
        r = $urandom_range(0, 31);
        if (r == 1) rate[i] = rate[i] + 8'd1;
        f = {rate[i], lk[i], 8'(i), cfgType};
        if (r == 0) f[7:0] = cfgType ^ 8'h40;
        if (r == 2 && cfgChkLink) f[15:8] = ~cfgLink;
        if (r == 3) f[23:16] = 8'(i) + 8'd1;
        stF[j][i] = f;
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    chk({tag, "_all_busy"}, 32'(bus0.busy), 0);
    chk({tag, "_all_finish"}, 32'(bus0.finish), 0);
    chk({tag, "_all_success"}, 32'(bus0.success), 0);
    chk({tag, "_all_laneQualified"}, 32'(bus0.laneQualified), 0);
    chk({tag, "_all_rateId"}, 32'(bus0.rateId), 0);
    chk({tag, "_any_busy"}, 32'(bus1.busy), 0);
    chk({tag, "_any_rateId"}, 32'(bus1.rateId), 0);
    chk({tag, "_any_linkNumberOut"}, 32'(bus1.linkNumberOut), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.orderedSets = '0;
    bus0.validOrderedSets = 1'b0; bus0.numberOfDetectedLanes = 6'd0;
    bus0.expectedType = 8'h00; bus0.linkNumber = 8'h00; bus0.checkLink = 1'b0;
    bus0.checkLane = 1'b0; bus0.threshold = '0; bus0.timeoutCycles = '0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b1;

    // back-to-back matching sets, no timeout
    setCfg(4, 8, 0); fillMatching(8'h02); runTest(0);
    // lane 2 bad type on the 5th set
    setCfg(4, 8, 0); fillMatching(8'h02); stF[5][2][7:0] = 8'h2D; runTest(0);
    // rate change on lane 0 at the 4th set; other lanes never match
    setCfg(4, 4, 30); fillMatching(8'h02);
    for (int unsigned j = 0; j < MAXJ + 2; j++) begin
      if (j >= 4) stF[j][0][31:24] = 8'h06;
      for (int unsigned i = 1; i < NL; i++) stF[j][i][7:0] = 8'h00;
    end
    runTest(0);
    // no valid sets, timeout 100
    setCfg(4, 4, 100); fillMatching(8'h02);
    for (int unsigned j = 0; j < MAXJ + 2; j++) stV[j] = 1'b0;
    runTest(0);
    // no detected lanes: only timeout ends the run
    setCfg(0, 1, 40); fillMatching(8'h02); runTest(0);
    // lane count above NUM_LANES clamps
    setCfg(6, 3, 0); fillMatching(8'h09); runTest(0);
    // threshold reached as the timer expires
    setCfg(4, 8, 9); fillMatching(8'h03); runTest(0);
    // threshold 0 behaves as 1
    setCfg(4, 0, 0); fillMatching(8'h07); runTest(0);
    // saturation: three lanes pass 31 matches, lane 3 never matches
    setCfg(4, 31, 50); fillMatching(8'h04);
    for (int unsigned j = 0; j < MAXJ + 2; j++) stF[j][3][23:16] = 8'h09;
    runTest(0);
    // restart mid-run: old counts must not carry over
    setCfg(4, 20, 0); fillMatching(8'h02); runTest(5);
    setCfg(4, 3, 0); fillMatching(8'h05); runTest(0);
    // abort mid-run
    setCfg(4, 20, 0); fillMatching(8'h02); runTest(6);
    @(negedge clk); bus0.abort = 1'b1;
    @(negedge clk); bus0.abort = 1'b0;
    chk("abort_all_busy", 32'(bus0.busy), 0);
    chk("abort_any_busy", 32'(bus1.busy), 0);
    repeat (4) @(negedge clk);
    chk("abort_all_laneQualified", 32'(bus0.laneQualified), 0);

    for (int t = 0; t < 40; t++) begin
      genRandom();
      runTest(0);
    end

    // reset mid-run clears outputs immediately
    setCfg(4, 20, 0); fillMatching(8'h02); runTest(5);
    chk("midrun_all_busy", 32'(bus0.busy), 1);
    reset = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
